// File: rtl/uart_pkg.sv
// Shared UART definitions: default divisor, sync character, autobaud FSM states.
package uart_pkg;

  localparam logic [15:0] DEFAULT_BAUD_DIVISOR = 16'd5208;
  localparam logic [7:0]  SYNC_CHAR            = 8'h55;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    WAIT_START,
    MEASURE,
    CHECK,
    DONE,
    ERROR
  } autobaud_state_t;

endpackage

// File: rtl/uart_autobaud_detect_if.sv
// Divisor handshake between the autobaud detector and the baud generator.
interface uart_autobaud_detect_if;
  logic [15:0] baud_divisor;
  logic        div_valid;
  logic        div_ready;

  modport master (output baud_divisor, output div_valid, input div_ready);
  modport slave  (input baud_divisor, input div_valid, output div_ready);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop rx synchronizer with rise/fall detect on the synchronized line; idles high.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic rx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;
  assign rise = ~rx_d & rx_s;

endmodule

// File: rtl/uart_autobaud_detect.sv
// Measures 8 bit periods of a 0x55 sync char and publishes the rounded clk/bit divisor.
// Optional AUTOBAUD_CHECK_EN adds per-segment timing validation in a CHECK state.
module uart_autobaud_detect
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W       = 19,
  parameter int unsigned MIN_DIVISOR = 16,
  parameter int unsigned IDLE_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          rx,
  uart_autobaud_detect_if.master        div_if,
  output logic                          busy,
  output logic                          err
);

  localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);

  autobaud_state_t   state;
  logic [IDLE_W-1:0] idle_cnt;
  logic [CNT_W-1:0]  meas_cnt;
  logic [1:0]        edge_cnt;
  logic              rx_s;
  logic              rx_fall;
  logic [CNT_W:0]    sum;
  logic [CNT_W:0]    res;
  logic              meas_sat;
  logic              res_bad;

`ifdef AUTOBAUD_CHECK_EN
  logic              rx_rise;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_s  (rx_s),
    .rise  (rx_rise),
    .fall  (rx_fall)
  );
`else
  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_s  (rx_s),
    .rise  (),
    .fall  (rx_fall)
  );
`endif

  // The span ending on this cycle is meas_cnt+1; +4 more rounds the /8 to nearest.
  assign sum      = {1'b0, meas_cnt} + (CNT_W+1)'(5);
  assign res      = sum >> 3;
  assign meas_sat = &meas_cnt;
  assign res_bad  = (res < (CNT_W+1)'(MIN_DIVISOR)) || (res > (CNT_W+1)'(17'h0FFFF));

`ifdef AUTOBAUD_CHECK_EN
  logic [CNT_W-1:0] seg_cnt;
  logic [CNT_W-1:0] seg_nx;
  logic [CNT_W-1:0] seg [8];
  logic [2:0]       seg_idx;
  logic [CNT_W-1:0] t_q;
  logic [CNT_W:0]   res_q;
  logic             bad_q;
  logic [CNT_W-1:0] seg_lo;
  logic [CNT_W-1:0] seg_hi;
  logic             seg_bad;

  assign seg_nx = seg_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_cnt <= '0;
      seg_idx <= '0;
      for (int unsigned i = 0; i < 8; i++) seg[i] <= '0;
    end else if (state == WAIT_START) begin
      seg_cnt <= '0;
      seg_idx <= '0;
    end else if (state == MEASURE) begin
      if (rx_rise || rx_fall) begin
        seg[seg_idx] <= seg_nx;
        seg_idx      <= seg_idx + 1'b1;
        seg_cnt      <= '0;
      end else begin
        seg_cnt <= seg_nx;
      end
    end
  end

  always_comb begin
    seg_lo  = (t_q >> 3) - (t_q >> 5);
    seg_hi  = (t_q >> 3) + (t_q >> 5);
    seg_bad = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (seg[i] < seg_lo || seg[i] > seg_hi) seg_bad = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      idle_cnt            <= '0;
      meas_cnt            <= '0;
      edge_cnt            <= '0;
      div_if.baud_divisor <= DEFAULT_BAUD_DIVISOR;
      div_if.div_valid    <= 1'b0;
      busy                <= 1'b0;
      err                 <= 1'b0;
`ifdef AUTOBAUD_CHECK_EN
      t_q                 <= '0;
      res_q               <= '0;
      bad_q               <= 1'b0;
`endif
    end else begin
      err <= 1'b0;
      if (!enable) begin
        state            <= IDLE;
        div_if.div_valid <= 1'b0;
        busy             <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            idle_cnt <= '0;
            state    <= WAIT_IDLE;
          end
          WAIT_IDLE: begin
            if (!rx_s) begin
              idle_cnt <= '0;
            end else if (idle_cnt == IDLE_W'(IDLE_CYCLES - 1)) begin
              idle_cnt <= '0;
              state    <= WAIT_START;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          WAIT_START: begin
            if (rx_fall) begin
              meas_cnt <= '0;
              edge_cnt <= '0;
              busy     <= 1'b1;
              state    <= MEASURE;
            end
          end
          MEASURE: begin
            if (meas_sat) begin
              busy  <= 1'b0;
              err   <= 1'b1;
              state <= ERROR;
            end else begin
              meas_cnt <= meas_cnt + 1'b1;
              if (rx_fall && edge_cnt == 2'd3) begin
                busy <= 1'b0;
`ifdef AUTOBAUD_CHECK_EN
                t_q   <= meas_cnt + 1'b1;
                res_q <= res;
                bad_q <= res_bad;
                state <= CHECK;
`else
                if (res_bad) begin
                  err   <= 1'b1;
                  state <= ERROR;
                end else begin
                  div_if.baud_divisor <= 16'(res);
                  div_if.div_valid    <= 1'b1;
                  state               <= DONE;
                end
`endif
              end else if (rx_fall) begin
                edge_cnt <= edge_cnt + 1'b1;
              end
            end
          end
`ifdef AUTOBAUD_CHECK_EN
          CHECK: begin
            if (bad_q || seg_bad) begin
              err   <= 1'b1;
              state <= ERROR;
            end else begin
              div_if.baud_divisor <= 16'(res_q);
              div_if.div_valid    <= 1'b1;
              state               <= DONE;
            end
          end
`endif
          DONE: begin
            if (div_if.div_ready) begin
              div_if.div_valid <= 1'b0;
              state            <= WAIT_IDLE;
            end
          end
          ERROR: state <= WAIT_IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_autobaud_detect.sv
// Directed bench for uart_autobaud_detect: 0x55 frames at several bit times, errors, aborts.
module tb_uart_autobaud_detect;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic rx = 1'b1;
  logic rx2 = 1'b1;
  logic busy, err, busy2, err2;
  logic [9:0] frame;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  int err2_seen = 0;

  uart_autobaud_detect_if dif ();
  uart_autobaud_detect_if dif2 ();

  uart_autobaud_detect dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .rx     (rx),
    .div_if (dif),
    .busy   (busy),
    .err    (err)
  );

  uart_autobaud_detect #(.CNT_W(12), .IDLE_CYCLES(64)) dut_to (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .rx     (rx2),
    .div_if (dif2),
    .busy   (busy2),
    .err    (err2)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (err) err_seen++;
    if (err2) err2_seen++;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input int len, input int first, input int last,
                           input int s_idx, input int s_len);
    for (int i = first; i <= last; i++) begin
      rx = frame[i];
      repeat ((i == s_idx) ? s_len : len) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dif.baud_divisor !== 16'd5208) begin errors++; $display("FAIL reset_div: got %0d want 5208", dif.baud_divisor); end
    checks++; if (dif.div_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dif.div_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_9600();
    int e0;
    enable = 1'b1;
    idle(2000);
    e0 = err_seen;
    send_bits(5208, 0, 4, -1, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b9600_busy: got %b want 1", busy); end
    send_bits(5208, 5, 9, -1, 0);
    checks++; if (dif.div_valid !== 1'b1) begin errors++; $display("FAIL b9600_valid: got %b want 1", dif.div_valid); end
    checks++; if (dif.baud_divisor !== 16'd5208) begin errors++; $display("FAIL b9600_div: got %0d want 5208", dif.baud_divisor); end
    checks++; if (err_seen - e0 !== 0) begin errors++; $display("FAIL b9600_err: got %0d want 0", err_seen - e0); end
    repeat (20) @(negedge clk);
    checks++; if (dif.div_valid !== 1'b1) begin errors++; $display("FAIL b9600_hold_valid: got %b want 1", dif.div_valid); end
    checks++; if (dif.baud_divisor !== 16'd5208) begin errors++; $display("FAIL b9600_hold_div: got %0d want 5208", dif.baud_divisor); end
    dif.div_ready = 1'b1;
    @(negedge clk);
    dif.div_ready = 1'b0;
    checks++; if (dif.div_valid !== 1'b0) begin errors++; $display("FAIL b9600_ack: got %b want 0", dif.div_valid); end
  endtask

  task automatic test_115200();
    logic stable;
    idle(1100);
    send_bits(434, 0, 9, -1, 0);
    checks++; if (dif.div_valid !== 1'b1) begin errors++; $display("FAIL b115200_valid: got %b want 1", dif.div_valid); end
    checks++; if (dif.baud_divisor !== 16'd434) begin errors++; $display("FAIL b115200_div: got %0d want 434", dif.baud_divisor); end
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dif.div_valid !== 1'b1 || dif.baud_divisor !== 16'd434) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL b115200_stable: got %b want 1", stable); end
    dif.div_ready = 1'b1;
    @(negedge clk);
    dif.div_ready = 1'b0;
    checks++; if (dif.div_valid !== 1'b0) begin errors++; $display("FAIL b115200_ack: got %b want 0", dif.div_valid); end
    checks++; if (dif.baud_divisor !== 16'd434) begin errors++; $display("FAIL b115200_keep: got %0d want 434", dif.baud_divisor); end
  endtask

  task automatic test_min_divisor();
    int e0;
    idle(1100);
    e0 = err_seen;
    send_bits(8, 0, 9, -1, 0);
    idle(20);
    checks++; if (err_seen - e0 !== 1) begin errors++; $display("FAIL min_err_cycles: got %0d want 1", err_seen - e0); end
    checks++; if (dif.baud_divisor !== 16'd434) begin errors++; $display("FAIL min_div_kept: got %0d want 434", dif.baud_divisor); end
    checks++; if (dif.div_valid !== 1'b0) begin errors++; $display("FAIL min_valid: got %b want 0", dif.div_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL min_busy: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    int n;
    int e0;
    e0 = err2_seen;
    n = 0;
    rx2 = 1'b0;
    while (err2 !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n < 4097 || n > 4101) begin errors++; $display("FAIL timeout_cycles: got %0d want 4099", n); end
    @(negedge clk);
    checks++; if (err2_seen - e0 !== 1) begin errors++; $display("FAIL timeout_err_cycles: got %0d want 1", err2_seen - e0); end
    checks++; if (dif2.div_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid: got %b want 0", dif2.div_valid); end
    rx2 = 1'b1;
  endtask

  task automatic test_reset_mid();
    idle(1100);
    send_bits(434, 0, 3, -1, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre: got %b want 1", busy); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (dif.baud_divisor !== 16'd5208) begin errors++; $display("FAIL rstmid_div: got %0d want 5208", dif.baud_divisor); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (dif.div_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", dif.div_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    send_bits(434, 4, 9, -1, 0);
  endtask

  task automatic test_enable_mid();
    int e0;
    idle(1100);
    e0 = err_seen;
    send_bits(434, 0, 3, -1, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL enmid_busy_pre: got %b want 1", busy); end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enmid_busy: got %b want 0", busy); end
    send_bits(434, 4, 9, -1, 0);
    checks++; if (dif.div_valid !== 1'b0) begin errors++; $display("FAIL enmid_valid: got %b want 0", dif.div_valid); end
    checks++; if (err_seen - e0 !== 0) begin errors++; $display("FAIL enmid_err: got %0d want 0", err_seen - e0); end
    enable = 1'b1;
  endtask

  task automatic test_stretch();
    int e0;
    idle(1100);
    e0 = err_seen;
    send_bits(434, 0, 9, 1, 651);
`ifdef AUTOBAUD_CHECK_EN
    checks++; if (err_seen - e0 !== 1) begin errors++; $display("FAIL stretch_err: got %0d want 1", err_seen - e0); end
    checks++; if (dif.div_valid !== 1'b0) begin errors++; $display("FAIL stretch_valid: got %b want 0", dif.div_valid); end
`else
    checks++; if (err_seen - e0 !== 0) begin errors++; $display("FAIL stretch_err: got %0d want 0", err_seen - e0); end
    checks++; if (dif.div_valid !== 1'b1) begin errors++; $display("FAIL stretch_valid: got %b want 1", dif.div_valid); end
    checks++; if (dif.baud_divisor !== 16'd461) begin errors++; $display("FAIL stretch_div: got %0d want 461", dif.baud_divisor); end
`endif
    dif.div_ready = 1'b1;
    @(negedge clk);
    dif.div_ready = 1'b0;
  endtask

  initial begin
    frame = {1'b1, SYNC_CHAR, 1'b0};
    dif.div_ready = 1'b0;
    dif2.div_ready = 1'b0;
    test_reset();
    test_9600();
    test_115200();
    test_min_divisor();
    test_timeout();
    test_reset_mid();
    test_enable_mid();
    test_stretch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
